exc_ctrl: RTL and testbench

- Precise-exception and interrupt sequencer for the CP0 register file.
- Samples the MEM-stage instruction each cycle and decides whether an exception, an interrupt or an ERET is taken.
- CP0 has a single write port, so the block serialises the EPC, Cause and Status updates through it, stalls the pipeline meanwhile, then issues one flush plus redirect PC.
- When idle it passes pipeline MTC0 writes straight through to CP0, acting as the sole owner of the CP0 write port.

---
 rtl/exc_ctrl.sv | 146 ++++++++++++++
 tb/tb_exc_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Precise-exception / interrupt / ERET sequencer owning the single CP0 write port.
// Serialises EPC, Cause and Status updates, stalls meanwhile, then flushes and redirects.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [4:0]  ADDR_STATUS = 5'd12,
  parameter logic [4:0]  ADDR_CAUSE  = 5'd13,
  parameter logic [4:0]  ADDR_EPC    = 5'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  output logic        exc_ready,
  input  logic [4:0]  exc_type,
  input  logic [31:0] exc_pc,
  input  logic        exc_in_delay,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_wdata_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam int unsigned CODE_W = 5;
  localparam int unsigned XLEN   = 32;

  localparam logic [CODE_W-1:0] CODE_INT = 5'd0;
  localparam logic [CODE_W-1:0] CODE_SYS = 5'd8;
  localparam logic [CODE_W-1:0] CODE_BP  = 5'd9;
  localparam logic [CODE_W-1:0] CODE_RI  = 5'd10;
  localparam logic [CODE_W-1:0] CODE_OV  = 5'd12;

  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STATUS, REDIRECT} state_t;

  state_t            state;
  logic [CODE_W-1:0] code_lat;
  logic              bd_lat;
  logic              eret_lat;
  logic [XLEN-1:0]   epc_val_lat;
  logic [XLEN-1:0]   status_lat;
  logic [25:0]       cause_keep_lat;   // Cause[30:7] and Cause[1:0]
  logic [XLEN-1:0]   epc_lat;

  logic              int_pend;
  logic              accept;
  logic              sel_eret;
  logic [CODE_W-1:0] sel_code;

  // Decide whether this cycle's MEM-stage instruction is taken, and with which code.
  always_comb begin
    int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
    accept   = rst && (state == IDLE) && exc_valid && (int_pend || (|exc_type));
    sel_eret = 1'b0;
    sel_code = CODE_INT;
    if (int_pend)         sel_code = CODE_INT;
    else if (exc_type[2]) sel_code = CODE_RI;
    else if (exc_type[3]) sel_code = CODE_OV;
    else if (exc_type[0]) sel_code = CODE_SYS;
    else if (exc_type[1]) sel_code = CODE_BP;
    else                  sel_eret = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      code_lat       <= '0;
      bd_lat         <= 1'b0;
      eret_lat       <= 1'b0;
      epc_val_lat    <= '0;
      status_lat     <= '0;
      cause_keep_lat <= '0;
      epc_lat        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            code_lat       <= sel_code;
            bd_lat         <= exc_in_delay;
            eret_lat       <= sel_eret;
            epc_val_lat    <= exc_in_delay ? XLEN'(exc_pc - 32'd4) : exc_pc;
            status_lat     <= status_i;
            cause_keep_lat <= {cause_i[30:7], cause_i[1:0]};
            epc_lat        <= epc_i;
            state          <= sel_eret ? W_STATUS : W_EPC;
          end
        end
        W_EPC:    state <= W_CAUSE;
        W_CAUSE:  state <= W_STATUS;
        W_STATUS: state <= REDIRECT;
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // CP0 port mux, stall and redirect decode.
  always_comb begin
    cp0_we_o    = 1'b0;
    cp0_waddr_o = '0;
    cp0_wdata_o = '0;
    stall_o     = 1'b0;
    flush_o     = 1'b0;
    new_pc_o    = '0;
    exc_ready   = (state == IDLE);
    case (state)
      IDLE: begin
        stall_o = accept;
        if (rst && !accept) begin
          cp0_we_o    = pipe_we_i;
          cp0_waddr_o = pipe_waddr_i;
          cp0_wdata_o = pipe_wdata_i;
        end
      end
      W_EPC: begin
        stall_o     = 1'b1;
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_EPC;
        cp0_wdata_o = epc_val_lat;
      end
      W_CAUSE: begin
        stall_o     = 1'b1;
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_CAUSE;
        cp0_wdata_o = {bd_lat, cause_keep_lat[25:2], code_lat, cause_keep_lat[1:0]};
      end
      W_STATUS: begin
        stall_o     = 1'b1;
        cp0_we_o    = 1'b1;
        cp0_waddr_o = ADDR_STATUS;
        cp0_wdata_o = eret_lat ? (status_lat & ~32'h2) : (status_lat | 32'h2);
      end
      REDIRECT: begin
        flush_o  = 1'b1;
        new_pc_o = eret_lat ? epc_lat : EXC_VECTOR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: per-cycle expected outputs are queued as stimulus is
// applied and popped/compared one per cycle.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic        exc_ready;
  logic [4:0]  exc_type;
  logic [31:0] exc_pc;
  logic        exc_in_delay;
  logic [31:0] status_i, cause_i, epc_i;
  logic        pipe_we_i;
  logic [4:0]  pipe_waddr_i;
  logic [31:0] pipe_wdata_i;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic        stall_o, flush_o;
  logic [31:0] new_pc_o;

  exc_ctrl dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_ready(exc_ready), .exc_type(exc_type),
    .exc_pc(exc_pc), .exc_in_delay(exc_in_delay),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
    .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        ready;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        flush;
    logic [31:0] pc;
  } obs_t;

  obs_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic obs_t mk(input logic st, input logic rd, input logic we,
                              input logic [4:0] a, input logic [31:0] d,
                              input logic fl, input logic [31:0] pc);
    obs_t o;
    o.stall = st; o.ready = rd; o.we = we; o.addr = a; o.data = d; o.flush = fl; o.pc = pc;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(stall_o, exc_ready, cp0_we_o, cp0_waddr_o, cp0_wdata_o, flush_o, new_pc_o);
  endfunction

  // Expected 5-cycle exception sequence from the acceptance cycle through redirect.
  task automatic push_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                          input logic [31:0] st, input logic [31:0] ca);
    logic [31:0] epc, cw;
    epc = bd ? pc - 32'd4 : pc;
    cw  = {bd, ca[30:7], code, ca[1:0]};
    sbq.push_back(mk(1, 1, 0, 5'd0, 32'd0, 0, 32'd0));
    sbq.push_back(mk(1, 0, 1, 5'd14, epc, 0, 32'd0));
    sbq.push_back(mk(1, 0, 1, 5'd13, cw, 0, 32'd0));
    sbq.push_back(mk(1, 0, 1, 5'd12, st | 32'h2, 0, 32'd0));
    sbq.push_back(mk(0, 0, 0, 5'd0, 32'd0, 1, 32'h20));
  endtask

  // Inputs were driven at the preceding negedge; compare mid-cycle, then advance.
  task automatic step(input string tag);
    obs_t o, e;
    #2;
    o = sample();
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $error("FAIL %s scoreboard empty, observed %h", tag, o);
    end else begin
      e = sbq.pop_front();
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s observed %h expected %h", tag, o, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    exc_valid = 0; exc_type = '0; exc_pc = '0; exc_in_delay = 0;
    status_i = '0; cause_i = '0; epc_i = '0;
    pipe_we_i = 0; pipe_waddr_i = '0; pipe_wdata_i = '0;
  endtask

  task automatic run_exc(input string tag, input logic [4:0] ty, input logic [31:0] pc,
                         input logic bd, input logic [31:0] st, input logic [31:0] ca);
    exc_valid = 1; exc_type = ty; exc_pc = pc; exc_in_delay = bd;
    status_i = st; cause_i = ca;
    step({tag, "_c0"});
    idle_inputs();
    for (int i = 1; i < 5; i++) step($sformatf("%s_c%0d", tag, i));
    sbq.push_back(mk(0, 1, 0, 5'd0, 32'd0, 0, 32'd0));
    step({tag, "_after"});
  endtask

  task automatic chk_now(input string tag, input obs_t e);
    obs_t o;
    o = sample();
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    @(negedge clk);
    sbq.push_back(mk(0, 1, 0, 5'd0, 32'd0, 0, 32'd0));
    step("reset_state");
    rst = 1;
    @(negedge clk);

    // Idle passthrough
    pipe_we_i = 1; pipe_waddr_i = 5'd11; pipe_wdata_i = 32'h64;
    sbq.push_back(mk(0, 1, 1, 5'd11, 32'h64, 0, 32'd0));
    step("passthru");
    // Valid with no cause: still passthrough
    exc_valid = 1; pipe_waddr_i = 5'd9; pipe_wdata_i = 32'hABCD;
    sbq.push_back(mk(0, 1, 1, 5'd9, 32'hABCD, 0, 32'd0));
    step("valid_no_exc");
    idle_inputs();

    // Syscall with pipe write in the acceptance cycle (suppressed)
    pipe_we_i = 1; pipe_waddr_i = 5'd11; pipe_wdata_i = 32'h64;
    push_exc(5'd8, 32'h100, 0, 32'h1000_0001, 32'h0);
    run_exc("sys", 5'b00001, 32'h100, 0, 32'h1000_0001, 32'h0);

    // Overflow + break in delay slot -> Ov wins
    push_exc(5'd12, 32'h204, 1, 32'h1, 32'h0);
    run_exc("ov_bd", 5'b01010, 32'h204, 1, 32'h1, 32'h0);

    // RI outranks Ov; Cause bits outside BD/ExcCode preserved
    push_exc(5'd10, 32'h300, 0, 32'h1, 32'h7F00_0F83);
    run_exc("ri", 5'b01100, 32'h300, 0, 32'h1, 32'h7F00_0F83);

    // Interrupt outranks syscall
    push_exc(5'd0, 32'h180, 0, 32'h401, 32'h400);
    run_exc("int", 5'b00001, 32'h180, 0, 32'h401, 32'h400);

    // Interrupt masked by EXL: no action
    exc_valid = 1; status_i = 32'h403; cause_i = 32'h400; exc_pc = 32'h180;
    sbq.push_back(mk(0, 1, 0, 5'd0, 32'd0, 0, 32'd0));
    step("int_masked");
    idle_inputs();
    sbq.push_back(mk(0, 1, 0, 5'd0, 32'd0, 0, 32'd0));
    step("int_masked_next");

    // ERET
    exc_valid = 1; exc_type = 5'b10000; epc_i = 32'h340; status_i = 32'h3; exc_pc = 32'h500;
    sbq.push_back(mk(1, 1, 0, 5'd0, 32'd0, 0, 32'd0));
    sbq.push_back(mk(1, 0, 1, 5'd12, 32'h1, 0, 32'd0));
    sbq.push_back(mk(0, 0, 0, 5'd0, 32'd0, 1, 32'h340));
    sbq.push_back(mk(0, 1, 0, 5'd0, 32'd0, 0, 32'd0));
    step("eret_c0");
    idle_inputs();
    step("eret_c1");
    step("eret_c2");
    step("eret_after");

    // Pipe write mid-sequence dropped, then async reset in W_CAUSE
    push_exc(5'd8, 32'h100, 0, 32'h1, 32'h0);
    exc_valid = 1; exc_type = 5'b00001; exc_pc = 32'h100; status_i = 32'h1;
    step("rst_c0");
    idle_inputs();
    pipe_we_i = 1; pipe_waddr_i = 5'd11; pipe_wdata_i = 32'h77;
    step("rst_c1");
    #2;
    chk_now("rst_wcause_pre", sbq.pop_front());
    #1;
    rst = 0;
    pipe_we_i = 0; pipe_waddr_i = '0; pipe_wdata_i = '0;
    #1;
    chk_now("rst_async", mk(0, 1, 0, 5'd0, 32'd0, 0, 32'd0));
    sbq.delete();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      sbq.push_back(mk(0, 1, 0, 5'd0, 32'd0, 0, 32'd0));
      step($sformatf("rst_noflush_%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
